// File: rtl/alu_rs.sv
// ---------------------------------------------------------------------------
// alu_rs -- ALU reservation station (CDB consumer).
//
// Holds dispatched ALU ops until both source operands are known, snoops the
// common data bus for pending operands, and issues ready ops through a
// single issue register with a valid/ready handshake toward the ALU.
//
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   flush               synchronous squash of all entries + issue register
//   disp_*              dispatch request (op, dest tag, two tagged sources)
//   disp_ready          station not full (registered state only)
//   cdb_tag/cdb_value   result broadcast; cdb_tag == NO_LOCK means idle
//   alu_*               issue register toward the ALU, alu_ready handshake
//   occupancy           number of valid entries
//
// Optional build macro RS_AGE_ORDER_EN: oldest-ready-first selection using a
// per-entry age counter. Without it the lowest-index ready entry issues.
// ---------------------------------------------------------------------------

// One station slot: op, dest tag, two tagged sources, plus optional age.
module alu_rs_entry #(
`ifdef RS_AGE_ORDER_EN
    parameter int AGE_W = 2,
`endif
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int OP_W   = 5,
    parameter logic [TAG_W-1:0] NO_LOCK = {TAG_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr_en,
    input  logic              clr,
    input  logic [OP_W-1:0]   wr_op,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [TAG_W-1:0]  wr_s1_tag,
    input  logic [DATA_W-1:0] wr_s1_val,
    input  logic [TAG_W-1:0]  wr_s2_tag,
    input  logic [DATA_W-1:0] wr_s2_val,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_value,
`ifdef RS_AGE_ORDER_EN
    input  logic [AGE_W-1:0]  wr_age,
    input  logic              age_dec,
    output logic [AGE_W-1:0]  age,
`endif
    output logic              valid,
    output logic              ready,
    output logic [OP_W-1:0]   op,
    output logic [TAG_W-1:0]  tag,
    output logic [DATA_W-1:0] s1_val,
    output logic [DATA_W-1:0] s2_val
);
    logic              valid_q,  valid_d;
    logic [OP_W-1:0]   op_q,     op_d;
    logic [TAG_W-1:0]  tag_q,    tag_d;
    logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;
    logic [DATA_W-1:0] s1_val_q, s1_val_d;
    logic [TAG_W-1:0]  s2_tag_q, s2_tag_d;
    logic [DATA_W-1:0] s2_val_q, s2_val_d;
    logic              cdb_live;

    assign cdb_live = (cdb_tag != NO_LOCK);

    always_comb begin
        valid_d  = valid_q;
        op_d     = op_q;
        tag_d    = tag_q;
        s1_tag_d = s1_tag_q;
        s1_val_d = s1_val_q;
        s2_tag_d = s2_tag_q;
        s2_val_d = s2_val_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (wr_en) begin
            // wr_en only targets a free slot, so it never collides with clr
            valid_d  = 1'b1;
            op_d     = wr_op;
            tag_d    = wr_tag;
            s1_tag_d = wr_s1_tag;
            s1_val_d = wr_s1_val;
            s2_tag_d = wr_s2_tag;
            s2_val_d = wr_s2_val;
        end else if (valid_q) begin
            if (clr) valid_d = 1'b0;
            if (cdb_live && s1_tag_q == cdb_tag) begin
                s1_tag_d = NO_LOCK;
                s1_val_d = cdb_value;
            end
            if (cdb_live && s2_tag_q == cdb_tag) begin
                s2_tag_d = NO_LOCK;
                s2_val_d = cdb_value;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            op_q     <= '0;
            tag_q    <= NO_LOCK;
            s1_tag_q <= NO_LOCK;
            s1_val_q <= '0;
            s2_tag_q <= NO_LOCK;
            s2_val_q <= '0;
        end else begin
            valid_q  <= valid_d;
            op_q     <= op_d;
            tag_q    <= tag_d;
            s1_tag_q <= s1_tag_d;
            s1_val_q <= s1_val_d;
            s2_tag_q <= s2_tag_d;
            s2_val_q <= s2_val_d;
        end
    end

`ifdef RS_AGE_ORDER_EN
    logic [AGE_W-1:0] age_q, age_d;

    always_comb begin
        age_d = age_q;
        if (wr_en)        age_d = wr_age;
        else if (age_dec) age_d = age_q - AGE_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) age_q <= '0;
        else     age_q <= age_d;
    end

    assign age = age_q;
`endif

    assign valid  = valid_q;
    assign ready  = valid_q && (s1_tag_q == NO_LOCK) && (s2_tag_q == NO_LOCK);
    assign op     = op_q;
    assign tag    = tag_q;
    assign s1_val = s1_val_q;
    assign s2_val = s2_val_q;
endmodule

module alu_rs #(
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 4,
    parameter logic [TAG_W-1:0] NO_LOCK = {TAG_W{1'b1}},
    parameter int OP_W    = 5,
    parameter int ENTRIES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         disp_valid,
    output logic                         disp_ready,
    input  logic [OP_W-1:0]              disp_op,
    input  logic [TAG_W-1:0]             disp_tag,
    input  logic [TAG_W-1:0]             disp_src1_tag,
    input  logic [DATA_W-1:0]            disp_src1_val,
    input  logic [TAG_W-1:0]             disp_src2_tag,
    input  logic [DATA_W-1:0]            disp_src2_val,
    input  logic [TAG_W-1:0]             cdb_tag,
    input  logic [DATA_W-1:0]            cdb_value,
    output logic                         alu_valid,
    input  logic                         alu_ready,
    output logic [OP_W-1:0]              alu_op,
    output logic [DATA_W-1:0]            alu_a,
    output logic [DATA_W-1:0]            alu_b,
    output logic [TAG_W-1:0]             alu_tag,
    output logic [$clog2(ENTRIES):0]     occupancy
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int OCC_W = IDX_W + 1;

    logic [ENTRIES-1:0]             e_valid, e_ready, e_wr, e_clr;
    logic [ENTRIES-1:0][OP_W-1:0]   e_op;
    logic [ENTRIES-1:0][TAG_W-1:0]  e_tag;
    logic [ENTRIES-1:0][DATA_W-1:0] e_s1_val, e_s2_val;

    logic [OCC_W-1:0]  occ_q, occ_d;
    logic              alu_valid_q, alu_valid_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [TAG_W-1:0]  alu_tag_q, alu_tag_d;

    logic              disp_fire, issue_load, issue_fire, any_ready;
    logic [IDX_W-1:0]  wr_idx, sel_idx;
    logic [TAG_W-1:0]  wr_s1_tag, wr_s2_tag;
    logic [DATA_W-1:0] wr_s1_val, wr_s2_val;

    assign disp_ready = (occ_q != OCC_W'(ENTRIES));
    assign disp_fire  = disp_valid && disp_ready && !flush;
    assign issue_load = !alu_valid_q || alu_ready;
    assign any_ready  = |e_ready;
    assign issue_fire = issue_load && any_ready && !flush;

    // Same-cycle bypass: a source waiting on the tag being broadcast right
    // now would otherwise miss it, since snoop only covers stored entries.
    always_comb begin
        wr_s1_tag = disp_src1_tag;
        wr_s1_val = disp_src1_val;
        wr_s2_tag = disp_src2_tag;
        wr_s2_val = disp_src2_val;
        if (disp_src1_tag != NO_LOCK && disp_src1_tag == cdb_tag) begin
            wr_s1_tag = NO_LOCK;
            wr_s1_val = cdb_value;
        end
        if (disp_src2_tag != NO_LOCK && disp_src2_tag == cdb_tag) begin
            wr_s2_tag = NO_LOCK;
            wr_s2_val = cdb_value;
        end
    end

    // Lowest-index free slot (scan downward so the lowest hit wins).
    always_comb begin
        wr_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--)
            if (!e_valid[i]) wr_idx = IDX_W'(i);
    end

`ifdef RS_AGE_ORDER_EN
    logic [ENTRIES-1:0][IDX_W-1:0] e_age;
    logic [ENTRIES-1:0]            e_age_dec;
    logic [IDX_W-1:0]              sel_age, wr_age;
    logic                          sel_found;

    // Oldest ready entry: ages are unique among valid entries.
    always_comb begin
        sel_idx   = '0;
        sel_age   = '0;
        sel_found = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (e_ready[i] && (!sel_found || e_age[i] < sel_age)) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_age   = e_age[i];
            end
        end
    end

    // New arrival lands behind every entry that survives this edge.
    assign wr_age = IDX_W'(occ_q - OCC_W'(issue_fire));

    always_comb begin
        for (int i = 0; i < ENTRIES; i++)
            e_age_dec[i] = issue_fire && e_valid[i] && (e_age[i] > sel_age);
    end
`else
    always_comb begin
        sel_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--)
            if (e_ready[i]) sel_idx = IDX_W'(i);
    end
`endif

    for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
        assign e_wr[g]  = disp_fire  && (wr_idx  == IDX_W'(g));
        assign e_clr[g] = issue_fire && (sel_idx == IDX_W'(g));

        alu_rs_entry #(
`ifdef RS_AGE_ORDER_EN
            .AGE_W   (IDX_W),
`endif
            .DATA_W  (DATA_W),
            .TAG_W   (TAG_W),
            .OP_W    (OP_W),
            .NO_LOCK (NO_LOCK)
        ) u_ent (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .wr_en     (e_wr[g]),
            .clr       (e_clr[g]),
            .wr_op     (disp_op),
            .wr_tag    (disp_tag),
            .wr_s1_tag (wr_s1_tag),
            .wr_s1_val (wr_s1_val),
            .wr_s2_tag (wr_s2_tag),
            .wr_s2_val (wr_s2_val),
            .cdb_tag   (cdb_tag),
            .cdb_value (cdb_value),
`ifdef RS_AGE_ORDER_EN
            .wr_age    (wr_age),
            .age_dec   (e_age_dec[g]),
            .age       (e_age[g]),
`endif
            .valid     (e_valid[g]),
            .ready     (e_ready[g]),
            .op        (e_op[g]),
            .tag       (e_tag[g]),
            .s1_val    (e_s1_val[g]),
            .s2_val    (e_s2_val[g])
        );
    end

    // Issue register: a stalled op holds every alu_* output.
    always_comb begin
        alu_valid_d = alu_valid_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_tag_d   = alu_tag_q;
        if (flush) begin
            alu_valid_d = 1'b0;
        end else if (issue_load) begin
            alu_valid_d = any_ready;
            if (any_ready) begin
                alu_op_d  = e_op[sel_idx];
                alu_a_d   = e_s1_val[sel_idx];
                alu_b_d   = e_s2_val[sel_idx];
                alu_tag_d = e_tag[sel_idx];
            end
        end
    end

    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else begin
            case ({disp_fire, issue_fire})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q       <= '0;
            alu_valid_q <= 1'b0;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_tag_q   <= NO_LOCK;
        end else begin
            occ_q       <= occ_d;
            alu_valid_q <= alu_valid_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_tag_q   <= alu_tag_d;
        end
    end

    assign alu_valid = alu_valid_q;
    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_tag   = alu_tag_q;
    assign occupancy = occ_q;
endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- ALU reservation station; the consumer end of the common data bus broadcast.
- Holds dispatched ALU ops until both operands are known.
- Snoops the CDB (tag, value) broadcast to capture pending operands.
- Issues ready ops to the ALU. The ALU result returns to the CDB with the entry's ROB tag.

Parameters:
- DATA_W, 32, operand/result width (matches Data_Width).
- TAG_W, 4, lock/ROB tag width (matches Reg_Lock_Width).
- NO_LOCK, 4'b1111 (all ones of TAG_W), tag value meaning "operand valid / no broadcast".
- OP_W, 5, ALU opcode width.
- ENTRIES, 4, station depth (power of two, >=2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- flush  in  1  synchronous squash of all entries and the issue register.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  station not full.
- disp_op  in  OP_W  opcode.
- disp_tag  in  TAG_W  destination ROB tag.
- disp_src1_tag  in  TAG_W  src1 lock tag; NO_LOCK means disp_src1_val is valid.
- disp_src1_val  in  DATA_W  src1 value.
- disp_src2_tag  in  TAG_W  src2 lock tag.
- disp_src2_val  in  DATA_W  src2 value.
- cdb_tag  in  TAG_W  broadcast tag; NO_LOCK means idle.
- cdb_value  in  DATA_W  broadcast value.
- alu_valid  out  1  issue register holds an op.
- alu_ready  in  1  ALU accepts this cycle.
- alu_op  out  OP_W  issued opcode.
- alu_a  out  DATA_W  operand 1.
- alu_b  out  DATA_W  operand 2.
- alu_tag  out  TAG_W  ROB tag. The ALU returns it as its result index.
- occupancy  out  clog2(ENTRIES)+1  number of valid entries.

Behaviour:
- Reset (async): all entry valid bits 0, every entry tag NO_LOCK.
  - alu_valid 0; alu_op/alu_a/alu_b 0; alu_tag NO_LOCK.
  - occupancy 0; disp_ready 1.
- Entry fields: valid, op, dest tag, and per source a tag plus value.
  - An entry is ready when valid and both source tags == NO_LOCK.
- disp_ready = (occupancy != ENTRIES). It is combinational from registered state only; a same-cycle issue does not free a slot for dispatch.
- Dispatch (disp_valid & disp_ready): writes the lowest-index free entry at the clock edge.
  - Per source: if disp_srcN_tag != NO_LOCK and equals cdb_tag this cycle, store cdb_value with tag NO_LOCK (same-cycle bypass).
  - Otherwise store the tag and value as given.
  - disp_valid while full: ignored, no state change.
- Snoop: every cycle, for every valid entry and each source whose tag equals cdb_tag (cdb_tag != NO_LOCK), capture cdb_value and set that tag to NO_LOCK.
  - Both sources may match the same broadcast.
  - cdb_tag == NO_LOCK never matches.
- Issue register load condition: (!alu_valid | alu_ready).
  - Select one ready entry from registered state.
  - Copy op/src1/src2/dest tag into alu_op/alu_a/alu_b/alu_tag; clear that entry's valid bit at the same edge.
  - If no entry is ready, alu_valid <= 0.
- Handshake: alu_valid & !alu_ready holds all alu_* outputs stable and no entry is selected.
- Latency:
  - Dispatch accepted in cycle N with ready (or bypassed) operands gives alu_valid from cycle N+2 if the issue register is free.
  - CDB broadcast in cycle N completing an entry gives alu_valid from N+2.
  - Back-to-back issue is one op per cycle while alu_ready=1.
- Simultaneous dispatch + issue: both take effect. Occupancy changes by +1-1=0.
- flush: at the next edge all valid bits 0, alu_valid 0, occupancy 0.
  - flush has priority over dispatch, snoop and issue.
- Reset mid-operation: immediate return to reset state. No partial entries survive.
- Occupancy is updated at every edge from dispatch/issue/flush. It never exceeds ENTRIES and never underflows.

Optional Feature:
- Macro RS_AGE_ORDER_EN.
- Defined:
  - Each entry keeps an age counter of clog2(ENTRIES) bits, set to the current occupancy minus issues on dispatch.
  - Age is decremented for older-than-removed entries on issue.
  - Selection picks the ready entry with the smallest age (oldest first).
- Undefined:
  - No age state; selection picks the lowest-index ready entry.
  - All other timing identical.

Test Plan:
- Reset, then dispatch op=3, tag=2, src1 NO_LOCK/0x10, src2 NO_LOCK/0x20, alu_ready=1 -> cycle N+2: alu_valid=1, alu_op=3, alu_a=0x10, alu_b=0x20, alu_tag=2; next cycle alu_valid=0, occupancy=0.
- Dispatch tag=1 with src1_tag=5, src2 ready 0x7; CDB 5/0xAB two cycles later -> alu_valid two cycles after broadcast with alu_a=0xAB, alu_b=0x7.
- Dispatch with src1_tag=6 while cdb_tag=6, cdb_value=0x55 same cycle -> bypass captured; alu_a=0x55 at N+2, no further broadcast needed.
- Fill 4 entries with unresolved tags -> disp_ready=0, fifth dispatch ignored. Broadcast resolving entry 2 -> issues entry 2; disp_ready=1 the cycle after it leaves.
- Hold alu_ready=0 with alu_valid=1 for 3 cycles -> alu_* outputs unchanged. Assert flush -> alu_valid=0, occupancy=0 next cycle.
- RS_AGE_ORDER_EN: dispatch A to entry 0 (pending), then B and C. Free entry 0 by issue, dispatch D into entry 0; make D and C ready same cycle -> C issues first. Without the macro D issues first.
